// File: rtl/range_arbiter.sv
// Round-robin arbiter that shares one range generator among NREQ requesters:
// it captures a winner's (base, limit, step), launches the generator, and steers its stream back.
module range_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  _clock,
  input  logic                  _reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_base,
  input  logic [NREQ*WIDTH-1:0] req_limit,
  input  logic [NREQ*WIDTH-1:0] req_step,
  output logic [NREQ-1:0]       ack,
  input  logic [NREQ-1:0]       out_ready,
  output logic [NREQ-1:0]       out_valid,
  output logic [WIDTH-1:0]      out_0,
  output logic [NREQ-1:0]       out_done,
  output logic [WIDTH-1:0]      out_count,
  output logic                  busy,
  output logic                  gen_start,
  output logic                  gen_ready,
  output logic [WIDTH-1:0]      gen_base,
  output logic [WIDTH-1:0]      gen_limit,
  output logic [WIDTH-1:0]      gen_step,
  input  logic                  gen_done,
  input  logic                  gen_valid,
  input  logic [WIDTH-1:0]      gen_0
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          rr_q;
  logic [IDX_W-1:0]          owner_p0;
  logic signed [WIDTH-1:0]   base_p0, limit_p0, step_p0;
  logic [WIDTH-1:0]          count_q;
  logic [WIDTH-1:0]          count_inc;

  logic [IDX_W-1:0]          pick;
  logic                      pick_ok;
  logic                      capture, finish, accept;
  logic [NREQ-1:0]           ack_raw;

  // Index addition modulo NREQ, which need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(NREQ)) s = s - (IDX_W+1)'(NREQ);
    return s[IDX_W-1:0];
  endfunction

  // Descending scan so the lowest offset from the rr pointer wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(rr_q, IDX_W'(k))]) begin
        pick    = wrap_add(rr_q, IDX_W'(k));
        pick_ok = 1'b1;
      end
    end
  end

  assign count_inc = count_q + {{(WIDTH-1){1'b0}}, accept};

  always_comb begin
    state_d   = state_q;
    ack_raw   = '0;
    out_valid = '0;
    out_done  = '0;
    out_0     = '0;
    out_count = '0;
    busy      = 1'b0;
    gen_start = 1'b0;
    gen_ready = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          ack_raw[pick] = 1'b1;
          capture       = 1'b1;
          state_d       = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        busy      = 1'b1;
        gen_start = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        busy                = 1'b1;
        gen_ready           = out_ready[owner_p0];
        out_valid[owner_p0] = gen_valid;
        out_0               = gen_0;
        accept              = gen_valid && gen_ready;
        if (gen_done && gen_ready) begin
          out_done[owner_p0] = 1'b1;
          out_count          = count_inc;
          finish             = 1'b1;
          state_d            = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Keeps ack quiet while reset is held even if requests are already raised.
  assign ack = ack_raw & {NREQ{_reset}};

  assign gen_base  = base_p0;
  assign gen_limit = limit_p0;
  assign gen_step  = step_p0;

  // Capture stage: winner index and its arguments.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      owner_p0 <= '0;
      base_p0  <= '0;
      limit_p0 <= '0;
      step_p0  <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        owner_p0 <= pick;
        base_p0  <= req_base[int'(pick)*WIDTH +: WIDTH];
        limit_p0 <= req_limit[int'(pick)*WIDTH +: WIDTH];
        step_p0  <= req_step[int'(pick)*WIDTH +: WIDTH];
      end
      if (state_q == S_LAUNCH) count_q <= '0;
      else if (accept)         count_q <= count_inc;
      if (finish) rr_q <= wrap_add(owner_p0, IDX_W'(1));
    end
  end

endmodule

// File: doc/range_arbiter.md
Name: range_arbiter

Overview:
- Shares one generator instance (e.g. hrange) among NREQ requesters, each asking for its own (base, limit, step) run.
- Arbitrates round-robin and launches the generator with the winner's arguments via the `_start`/`_ready`/`_valid`/`_done` handshake.
- Steers the output stream and backpressure to the winner, then reports completion and the item count.
- Sits between client FSMs and the single shared generator datapath.

Parameters:
- NREQ, 2, number of requesters (2..8)
- WIDTH, 32, signed argument/data width

Ports:
- `_clock` in 1: rising-edge clock.
- `_reset` in 1: asynchronous, active-low reset.
- `req` in NREQ: request level per requester; held until the matching `ack` bit.
- `req_base` in NREQ*WIDTH: per-requester base, slice i = [i*WIDTH +: WIDTH].
- `req_limit` in NREQ*WIDTH: per-requester limit.
- `req_step` in NREQ*WIDTH: per-requester step.
- `ack` out NREQ: one-hot, 1-cycle pulse when a request is captured.
- `out_ready` in NREQ: per-requester consumer ready.
- `out_valid` out NREQ: one-hot, owner's bit = `gen_valid` during RUN.
- `out_0` out WIDTH: forwarded generator data (shared bus).
- `out_done` out NREQ: one-hot, 1-cycle pulse at owner's transaction end.
- `out_count` out WIDTH: items delivered in the finished transaction; valid while `out_done`.
- `busy` out 1: high in LAUNCH or RUN.
- `gen_start` out 1: generator start.
- `gen_ready` out 1: generator ready.
- `gen_base`, `gen_limit`, `gen_step` out WIDTH each: generator arguments.
- `gen_done` in 1, `gen_valid` in 1, `gen_0` in WIDTH: generator outputs.

Behaviour:
- Reset (`_reset`=0, async):
  - State=IDLE, rr pointer=0, owner=0, count=0.
  - All outputs 0, including `gen_start`, `gen_ready`, `ack`, `out_*`, `busy`.
  - Deassertion takes effect at the next edge.
- FSM IDLE -> LAUNCH -> RUN -> IDLE.
- IDLE:
  - If any `req`, pick the first set bit scanning from the rr pointer upward, wrapping modulo NREQ.
  - Register owner and its base/limit/step, pulse `ack[owner]` in the same cycle, next state LAUNCH.
  - Nothing happens otherwise.
- LAUNCH (exactly 1 cycle):
  - `gen_start`=1 with registered args on `gen_base`/`gen_limit`/`gen_step`; `gen_ready`=0.
  - `gen_done` and `gen_valid` are ignored. Count is cleared. Next state RUN.
- RUN:
  - `gen_ready` = `out_ready[owner]`; `out_valid[owner]` = `gen_valid`; `out_0` = `gen_0`, combinational pass-through with zero latency.
  - Count increments on each cycle with `gen_valid` && `gen_ready`.
  - A cycle with `gen_done` && `gen_ready` ends the transaction:
    - pulse `out_done[owner]`;
    - `out_count` = count, including an item accepted in that same cycle;
    - rr pointer = (owner+1) mod NREQ;
    - next state IDLE.
  - If `gen_done` is high while `gen_ready`=0, hold in RUN.
- Outside RUN: `gen_ready`=0, `out_valid`=0, `out_0`=0.
- `gen_args` are driven from registers in all states and change only on capture.
- Minimum spacing between two launches: 1 IDLE cycle after `out_done`.
- A newly raised `req` from the owner during RUN is not served until IDLE, and only after higher-rr-priority requesters.
- `req` dropped before `ack`: not served, no error.
- Simultaneous `req` from all: strict rotation starting at requester 0 after reset; no starvation; worst-case wait = NREQ-1 transactions.
- Count wraps modulo 2^WIDTH. Arguments are passed through unmodified; the arbiter does no range arithmetic.
- Reset mid-RUN: the arbiter returns to IDLE immediately. The client must reset the generator with the same reset.

Test Plan:
- Single request: after reset, `req[0]`=1 with (0,10,2).
  - `ack[0]` pulses, `gen_start` for 1 cycle with those args.
  - `out_valid[0]` delivers 0,2,4,6,8.
  - `out_done[0]` pulses with `out_count`=5; `busy` falls.
- Contention: `req`=2'b11 simultaneously, requester 0 args (0,10,2), requester 1 args (1,11,3).
  - Requester 0 is served first (0,2,4,6,8; count 5).
  - Requester 1 follows after one IDLE cycle (1,4,7,10; count 4).
  - `out_valid[1]` is never high during requester 0's run.
- Rotation: requester 0 re-requests continuously while requester 1 requests once.
  - After requester 0's run, requester 1 is granted next (rr pointer=1).
- Backpressure: `out_ready[0]` toggled 1,0,0,1,... during (0,10,2).
  - `gen_ready` mirrors it. Data sequence 0,2,4,6,8 is unchanged; no duplicates or losses.
  - `out_done` is delayed until done coincides with ready; count=5.
- Empty range (5,5,1):
  - `gen_start` pulses, `out_valid` never asserts, `out_done` pulses with `out_count`=0.
- Async reset mid-RUN: assert `_reset`=0 between clock edges after the 2nd item.
  - All outputs are 0 immediately and state is IDLE.
  - After release, `req[1]`-only is served with the rr pointer back at 0.
